// File: rtl/cop0_exception_if.sv
// CP0 exception-unit bus between the control decoder (master) and CP0 (slave).
// Optional feature macro: CP0_IRQ_EN adds the level-sensitive irq line.
interface cop0_exception_if;
  logic        valid;
  logic        exc_ri;
  logic        exc_sys;
  logic        exc_ret;
  logic        cowrite;
  logic [4:0]  co_addr;
  logic [31:0] co_wdata;
  logic [31:0] pc;
`ifdef CP0_IRQ_EN
  logic        irq;
`endif
  logic [31:0] co_rdata;
  logic        user_mode;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
`ifdef CP0_IRQ_EN
    output irq,
`endif
    output valid, exc_ri, exc_sys, exc_ret, cowrite, co_addr, co_wdata, pc,
    input  co_rdata, user_mode, redirect, redirect_pc
  );

  modport slave (
`ifdef CP0_IRQ_EN
    input  irq,
`endif
    input  valid, exc_ri, exc_sys, exc_ret, cowrite, co_addr, co_wdata, pc,
    output co_rdata, user_mode, redirect, redirect_pc
  );
endinterface

// File: rtl/cop0_exception.sv
// CP0 exception unit: STATUS/CAUSE/EPC, exception/ERET sequencing and a
// one-cycle registered PC redirect. Optional macro CP0_IRQ_EN enables the
// external interrupt (INT) source.
module cop0_exception (
  input  logic               clk,
  input  logic               reset,
  cop0_exception_if.slave    bus
);
  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [4:0]  IDX_STATUS = 5'd12;
  localparam logic [4:0]  IDX_CAUSE  = 5'd13;
  localparam logic [4:0]  IDX_EPC    = 5'd14;
  localparam logic [4:0]  CODE_INT   = 5'd0;
  localparam logic [4:0]  CODE_SYS   = 5'd8;
  localparam logic [4:0]  CODE_RI    = 5'd10;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;

  state_t      state, state_d;
  logic        ie, pie, um, pum;
  logic        ie_d, pie_d, um_d, pum_d;
  logic [4:0]  code, code_d;
  logic [31:0] epc, epc_d;
  logic        redirect, redirect_d;
  logic [31:0] redirect_pc, redirect_pc_d;
  logic        int_req;
  logic        exc_take;
  logic [4:0]  exc_code;

`ifdef CP0_IRQ_EN
  assign int_req = bus.irq & ie;
`else
  assign int_req = 1'b0;
`endif

  // Event selection and next-state computation for the FSM and CP0 registers
  always_comb begin
    state_d       = state;
    ie_d          = ie;
    pie_d         = pie;
    um_d          = um;
    pum_d         = pum;
    code_d        = code;
    epc_d         = epc;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc;
    exc_take      = 1'b0;
    exc_code      = CODE_INT;

    unique case (state)
      IDLE: begin
        if (bus.valid) begin
          if (bus.exc_ri) begin
            exc_take = 1'b1;
            exc_code = CODE_RI;
          end else if (bus.exc_sys) begin
            exc_take = 1'b1;
            exc_code = CODE_SYS;
          end else if (int_req) begin
            exc_take = 1'b1;
            exc_code = CODE_INT;
          end

          if (exc_take) begin
            epc_d         = bus.pc;
            code_d        = exc_code;
            pum_d         = um;
            pie_d         = ie;
            um_d          = 1'b0;
            ie_d          = 1'b0;
            redirect_d    = 1'b1;
            redirect_pc_d = EXC_VECTOR;
            state_d       = FLUSH;
          end else if (bus.exc_ret) begin
            um_d          = pum;
            ie_d          = pie;
            redirect_d    = 1'b1;
            redirect_pc_d = epc;
            state_d       = FLUSH;
          end else if (bus.cowrite) begin
            unique case (bus.co_addr)
              IDX_STATUS: begin
                ie_d  = bus.co_wdata[0];
                pie_d = bus.co_wdata[1];
                um_d  = bus.co_wdata[4];
                pum_d = bus.co_wdata[5];
              end
              IDX_CAUSE: code_d = bus.co_wdata[6:2];
              IDX_EPC:   epc_d  = bus.co_wdata;
              default:   ;
            endcase
          end
        end
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ie          <= 1'b0;
      pie         <= 1'b0;
      um          <= 1'b0;
      pum         <= 1'b0;
      code        <= '0;
      epc         <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state       <= state_d;
      ie          <= ie_d;
      pie         <= pie_d;
      um          <= um_d;
      pum         <= pum_d;
      code        <= code_d;
      epc         <= epc_d;
      redirect    <= redirect_d;
      redirect_pc <= redirect_pc_d;
    end
  end

  // MFC0 read mux on current register contents
  always_comb begin
    bus.co_rdata = '0;
    unique case (bus.co_addr)
      IDX_STATUS: bus.co_rdata = {26'd0, pum, um, 2'b00, pie, ie};
      IDX_CAUSE:  bus.co_rdata = {25'd0, code, 2'b00};
      IDX_EPC:    bus.co_rdata = epc;
      default:    bus.co_rdata = '0;
    endcase
  end

  assign bus.user_mode   = um;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = redirect_pc;
endmodule

// File: tb/tb_cop0_exception.sv
// Directed bench for cop0_exception: vector table plus hand-written sequences
// for reset, read-before-update, unmapped indices and (with CP0_IRQ_EN) INT.
module tb_cop0_exception;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cop0_exception_if bus();

  cop0_exception dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, ri, sys, ret, cw;
    logic [4:0]  addr;
    logic [31:0] wdata, pc;
    logic        e_red;
    logic [31:0] e_rpc;
    logic        e_um;
    logic [31:0] e_status, e_cause, e_epc;
  } vec_t;

  localparam int unsigned NVEC = 20;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic v, logic ri, logic sys, logic ret, logic cw,
                              logic [4:0] addr, logic [31:0] wdata, logic [31:0] pc,
                              logic e_red, logic [31:0] e_rpc, logic e_um,
                              logic [31:0] e_status, logic [31:0] e_cause,
                              logic [31:0] e_epc);
    vec_t t;
    t.valid = v; t.ri = ri; t.sys = sys; t.ret = ret; t.cw = cw;
    t.addr = addr; t.wdata = wdata; t.pc = pc;
    t.e_red = e_red; t.e_rpc = e_rpc; t.e_um = e_um;
    t.e_status = e_status; t.e_cause = e_cause; t.e_epc = e_epc;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic ri, logic sys, logic ret, logic cw,
                       logic [4:0] addr, logic [31:0] wdata, logic [31:0] pc);
    bus.valid = v; bus.exc_ri = ri; bus.exc_sys = sys; bus.exc_ret = ret;
    bus.cowrite = cw; bus.co_addr = addr; bus.co_wdata = wdata; bus.pc = pc;
`ifdef CP0_IRQ_EN
    bus.irq = 1'b0;
`endif
  endtask

  // Called at posedge+1: checks outputs, then reads the three CP0 registers.
  task automatic check_state(string tag, logic e_red, logic [31:0] e_rpc, logic e_um,
                             logic [31:0] e_status, logic [31:0] e_cause,
                             logic [31:0] e_epc);
    check({tag, ".redirect"}, {31'd0, bus.redirect}, {31'd0, e_red});
    check({tag, ".redirect_pc"}, bus.redirect_pc, e_rpc);
    check({tag, ".user_mode"}, {31'd0, bus.user_mode}, {31'd0, e_um});
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, '0, '0);
    #1 check({tag, ".status"}, bus.co_rdata, e_status);
    bus.co_addr = 5'd13;
    #1 check({tag, ".cause"}, bus.co_rdata, e_cause);
    bus.co_addr = 5'd14;
    #1 check({tag, ".epc"}, bus.co_rdata, e_epc);
  endtask

  initial begin
    //               v  ri sy rt cw addr   wdata          pc            red rpc           um status        cause         epc
    vecs[0]  = mk(1, 0, 0, 0, 1, 5'd12, 32'h0000_0011, 32'h0,        0, 32'h0,        1, 32'h11, 32'h00, 32'h0);
    vecs[1]  = mk(1, 0, 1, 0, 0, 5'd0,  32'h0,         32'h0000_0400, 1, 32'h80,       0, 32'h22, 32'h20, 32'h400);
    vecs[2]  = mk(0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        0, 32'h80,       0, 32'h22, 32'h20, 32'h400);
    vecs[3]  = mk(1, 0, 0, 1, 0, 5'd0,  32'h0,         32'h0,        1, 32'h400,      1, 32'h33, 32'h20, 32'h400);
    vecs[4]  = mk(1, 0, 1, 0, 0, 5'd0,  32'h0,         32'h0000_0999, 0, 32'h400,      1, 32'h33, 32'h20, 32'h400);
    vecs[5]  = mk(1, 1, 0, 0, 1, 5'd14, 32'hDEAD_BEEF, 32'h0000_1234, 1, 32'h80,       0, 32'h22, 32'h28, 32'h1234);
    vecs[6]  = mk(1, 0, 0, 0, 1, 5'd12, 32'h0000_00FF, 32'h0,        0, 32'h80,       0, 32'h22, 32'h28, 32'h1234);
    vecs[7]  = mk(0, 0, 0, 0, 1, 5'd13, 32'hFFFF_FFFF, 32'h0,        0, 32'h80,       0, 32'h22, 32'h28, 32'h1234);
    vecs[8]  = mk(1, 0, 0, 0, 1, 5'd13, 32'hFFFF_FFFF, 32'h0,        0, 32'h80,       0, 32'h22, 32'h7C, 32'h1234);
    vecs[9]  = mk(1, 0, 0, 0, 1, 5'd12, 32'hFFFF_FFFF, 32'h0,        0, 32'h80,       1, 32'h33, 32'h7C, 32'h1234);
    vecs[10] = mk(1, 0, 0, 0, 1, 5'd14, 32'hCAFE_F00D, 32'h0,        0, 32'h80,       1, 32'h33, 32'h7C, 32'hCAFEF00D);
    vecs[11] = mk(1, 0, 0, 0, 1, 5'd5,  32'h1234_5678, 32'h0,        0, 32'h80,       1, 32'h33, 32'h7C, 32'hCAFEF00D);
    vecs[12] = mk(1, 1, 1, 0, 0, 5'd0,  32'h0,         32'h0000_0500, 1, 32'h80,       0, 32'h22, 32'h28, 32'h500);
    vecs[13] = mk(0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        0, 32'h80,       0, 32'h22, 32'h28, 32'h500);
    vecs[14] = mk(1, 0, 0, 1, 1, 5'd12, 32'h0,         32'h0,        1, 32'h500,      1, 32'h33, 32'h28, 32'h500);
    vecs[15] = mk(0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        0, 32'h500,      1, 32'h33, 32'h28, 32'h500);
    vecs[16] = mk(1, 0, 1, 1, 0, 5'd0,  32'h0,         32'h0000_0600, 1, 32'h80,       0, 32'h22, 32'h20, 32'h600);
    vecs[17] = mk(0, 0, 0, 0, 0, 5'd0,  32'h0,         32'h0,        0, 32'h80,       0, 32'h22, 32'h20, 32'h600);
    vecs[18] = mk(0, 0, 0, 1, 0, 5'd0,  32'h0,         32'h0,        0, 32'h80,       0, 32'h22, 32'h20, 32'h600);
    vecs[19] = mk(1, 0, 0, 0, 1, 5'd12, 32'h0000_0010, 32'h0,        0, 32'h80,       1, 32'h10, 32'h20, 32'h600);

    // Reset, with an event pending to show reset wins
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, '0, 32'h100);
    repeat (2) @(posedge clk);
    #1 check_state("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk) reset = 1'b0;

    for (int unsigned i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].ri, vecs[i].sys, vecs[i].ret, vecs[i].cw,
            vecs[i].addr, vecs[i].wdata, vecs[i].pc);
      @(posedge clk);
      #1 check_state($sformatf("v%0d", i), vecs[i].e_red, vecs[i].e_rpc, vecs[i].e_um,
                     vecs[i].e_status, vecs[i].e_cause, vecs[i].e_epc);
    end

    // MFC0 shows the old value while an MTC0 to the same register is pending
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0033, 32'h0);
    #1 check("rd_before_update", bus.co_rdata, 32'h10);
    @(posedge clk);
    #1 check_state("mtc0_status", 1'b0, 32'h80, 1'b1, 32'h33, 32'h20, 32'h600);

    // Unmapped indices read zero
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, '0, '0);
    #1 check("rd_idx7", bus.co_rdata, 32'h0);
    bus.co_addr = 5'd5;
    #1 check("rd_idx5", bus.co_rdata, 32'h0);

    // Reset asserted during FLUSH
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, '0, 32'h700);
    @(posedge clk);
    #1 check_state("sys2", 1'b1, 32'h80, 1'b0, 32'h22, 32'h20, 32'h700);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, '0, 32'h704);
    @(posedge clk);
    #1 check_state("rst_flush", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, '0, 32'h800);
    @(posedge clk);
    #1 check_state("ri_after_rst", 1'b1, 32'h80, 1'b0, 32'h0, 32'h28, 32'h800);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    @(posedge clk);
    #1 check_state("flush_end", 1'b0, 32'h80, 1'b0, 32'h0, 32'h28, 32'h800);

`ifdef CP0_IRQ_EN
    // irq ignored while IE=0
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, 32'h1FC);
    bus.irq = 1'b1;
    @(posedge clk);
    #1 check_state("irq_masked", 1'b0, 32'h80, 1'b0, 32'h0, 32'h28, 32'h800);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0001, 32'h0);
    @(posedge clk);
    #1 check_state("ie_set", 1'b0, 32'h80, 1'b0, 32'h1, 32'h28, 32'h800);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, 32'h200);
    bus.irq = 1'b1;
    @(posedge clk);
    #1 check_state("irq_taken", 1'b1, 32'h80, 1'b0, 32'h2, 32'h0, 32'h200);
`else
    // IE writable, no irq source: nothing is taken
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0001, 32'h0);
    @(posedge clk);
    #1 check_state("ie_set", 1'b0, 32'h80, 1'b0, 32'h1, 32'h28, 32'h800);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, '0, 32'h200);
    @(posedge clk);
    #1 check_state("no_int", 1'b0, 32'h80, 1'b0, 32'h1, 32'h28, 32'h800);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
